// File: rtl/alu_mem_pipe_reg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_mem_pipe_reg
//  Description : ALU->MEM pipeline register with a two-entry skid buffer.
//                in_ready is decoded from state only, so there is no
//                combinational path from out_ready back to in_ready.
//                out_ctrl is forced to zero on bubbles.
//  Revision    : 1.0  initial release
// ============================================================================
module alu_mem_pipe_reg #(
    parameter int DATA_W = 24,
    parameter int CTRL_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_alu_result,
    input  logic [DATA_W-1:0] in_write_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_alu_result,
    output logic [DATA_W-1:0] out_write_data,
    output logic [1:0]        occupancy
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t              state_q, state_d;

    logic [CTRL_W-1:0]   main_ctrl_q;
    logic [DATA_W-1:0]   main_alu_q;
    logic [DATA_W-1:0]   main_wd_q;
    logic [CTRL_W-1:0]   skid_ctrl_q;
    logic [DATA_W-1:0]   skid_alu_q;
    logic [DATA_W-1:0]   skid_wd_q;

    logic                w_in_fire;
    logic                w_out_fire;
    logic                w_load_main_in;
    logic                w_load_main_skid;
    logic                w_load_skid;

    assign in_ready   = (state_q != S_FULL);
    assign out_valid  = (state_q != S_EMPTY);
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;

    // Bubbles never carry write/mem-enable bits downstream.
    assign out_ctrl       = out_valid ? main_ctrl_q : '0;
    assign out_alu_result = main_alu_q;
    assign out_write_data = main_wd_q;

    // Occupancy decoded from state.
    always_comb begin
        occupancy = 2'd0;
        case (state_q)
            S_ONE:   occupancy = 2'd1;
            S_FULL:  occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    // Next-state and register-load selection; flush overrides everything.
    always_comb begin
        state_d          = state_q;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (state_q)
            S_EMPTY: begin
                if (w_in_fire) begin
                    w_load_main_in = 1'b1;
                    state_d        = S_ONE;
                end
            end
            S_ONE: begin
                if (w_in_fire && w_out_fire) begin
                    w_load_main_in = 1'b1;
                end else if (w_in_fire) begin
                    w_load_skid = 1'b1;
                    state_d     = S_FULL;
                end else if (w_out_fire) begin
                    state_d = S_EMPTY;
                end
            end
            S_FULL: begin
                if (w_out_fire) begin
                    w_load_main_skid = 1'b1;
                    state_d          = S_ONE;
                end
            end
            default: state_d = S_EMPTY;
        endcase
        if (flush) begin
            state_d          = S_EMPTY;
            w_load_main_in   = 1'b0;
            w_load_main_skid = 1'b0;
            w_load_skid      = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Main (output) entry: loaded from the input or promoted from the skid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_ctrl_q <= '0;
            main_alu_q  <= '0;
            main_wd_q   <= '0;
        end else if (w_load_main_in) begin
            main_ctrl_q <= in_ctrl;
            main_alu_q  <= in_alu_result;
            main_wd_q   <= in_write_data;
        end else if (w_load_main_skid) begin
            main_ctrl_q <= skid_ctrl_q;
            main_alu_q  <= skid_alu_q;
            main_wd_q   <= skid_wd_q;
        end
    end

    // Skid entry: captures the input when the main entry is stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            skid_ctrl_q <= '0;
            skid_alu_q  <= '0;
            skid_wd_q   <= '0;
        end else if (w_load_skid) begin
            skid_ctrl_q <= in_ctrl;
            skid_alu_q  <= in_alu_result;
            skid_wd_q   <= in_write_data;
        end
    end

endmodule
`default_nettype wire
